// File: rtl/game_pkg.sv
// Shared constants and types for the Go Board game input path.
package game_pkg;

    localparam int unsigned NUM_BTN           = 4;
    localparam int unsigned BTN_UP            = 0;
    localparam int unsigned BTN_DN            = 1;
    localparam int unsigned BTN_LT            = 2;
    localparam int unsigned BTN_RT            = 3;
    localparam int unsigned CLKS_PER_MS_25MHZ = 25000;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, ms-tick debounce and typematic auto-repeat FSM.
module btn_debounce
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned REPEAT_DELAY_MS = 400,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Raw,
    input  logic i_Tick,
    input  logic i_Freeze,
    output logic o_Level,
    output logic o_Pulse
);

    localparam int unsigned RPT_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                         : REPEAT_RATE_MS;
    localparam int unsigned DB_W    = cnt_width(DEBOUNCE_MS);
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_MS - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_MS - 1);

    logic [1:0]       sync_q;
    logic             sync_lvl;
    logic             level_q;
    logic             level_nxt;
    logic [DB_W-1:0]  db_cnt_q;
    logic [DB_W-1:0]  db_cnt_nxt;
    rpt_state_e       state_q;
    rpt_state_e       state_nxt;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             pulse_q;
    logic             pulse_nxt;

    assign sync_lvl = sync_q[1];
    assign o_Level  = level_q;
    assign o_Pulse  = pulse_q;

    // Debounce: level follows the synchronised input only after DEBOUNCE_MS ticks of disagreement.
    always_comb begin
        level_nxt  = level_q;
        db_cnt_nxt = '0;
        if (sync_lvl != level_q) begin
            db_cnt_nxt = db_cnt_q;
            if (i_Tick) begin
                if (db_cnt_q == DB_LAST) begin
                    level_nxt  = sync_lvl;
                    db_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt_q + DB_W'(1);
                end
            end
        end
    end

    // Repeat FSM is driven from level_nxt so the press pulse lands with the level update.
    always_comb begin
        state_nxt   = state_q;
        rpt_cnt_nxt = rpt_cnt_q;
        pulse_nxt   = 1'b0;
        if (!level_nxt) begin
            state_nxt   = RPT_IDLE;
            rpt_cnt_nxt = '0;
        end else begin
            unique case (state_q)
                RPT_IDLE: begin
                    state_nxt   = RPT_DELAY;
                    rpt_cnt_nxt = '0;
                    pulse_nxt   = 1'b1;
                end
                RPT_DELAY: begin
                    if (i_Freeze) begin
                        rpt_cnt_nxt = '0;
                    end else if (i_Tick) begin
                        if (rpt_cnt_q == DELAY_LAST) begin
                            state_nxt   = RPT_REPEAT;
                            rpt_cnt_nxt = '0;
                            pulse_nxt   = 1'b1;
                        end else begin
                            rpt_cnt_nxt = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                end
                RPT_REPEAT: begin
                    if (i_Freeze) begin
                        state_nxt   = RPT_DELAY;
                        rpt_cnt_nxt = '0;
                    end else if (i_Tick) begin
                        if (rpt_cnt_q == RATE_LAST) begin
                            rpt_cnt_nxt = '0;
                            pulse_nxt   = 1'b1;
                        end else begin
                            rpt_cnt_nxt = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt   = RPT_IDLE;
                    rpt_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q    <= 2'b00;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= RPT_IDLE;
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_Raw};
            level_q   <= level_nxt;
            db_cnt_q  <= db_cnt_nxt;
            state_q   <= state_nxt;
            rpt_cnt_q <= rpt_cnt_nxt;
            pulse_q   <= pulse_nxt;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Go Board button front end: 1 ms prescaler, four conditioned buttons and the Up+Dn reset combo.
module button_conditioner
    import game_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS     = CLKS_PER_MS_25MHZ,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned REPEAT_DELAY_MS = 400,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned COMBO_HOLD_MS   = 1000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic [NUM_BTN-1:0] i_Btn_Raw,
    output logic [NUM_BTN-1:0] o_Btn_Level,
    output logic [NUM_BTN-1:0] o_Move_Pulse,
    output logic               o_Combo_Reset,
    output logic               o_Ms_Tick
);

    localparam int unsigned PS_W  = cnt_width(CLKS_PER_MS);
    localparam int unsigned CMB_W = cnt_width(COMBO_HOLD_MS);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLKS_PER_MS - 1);
    localparam logic [CMB_W-1:0] CMB_FULL = CMB_W'(COMBO_HOLD_MS);
    localparam logic [CMB_W-1:0] CMB_LAST = CMB_W'(COMBO_HOLD_MS - 1);

    logic [PS_W-1:0]    presc_q;
    logic [PS_W-1:0]    presc_nxt;
    logic               ms_tick_q;
    logic [CMB_W-1:0]   combo_cnt_q;
    logic [CMB_W-1:0]   combo_cnt_nxt;
    logic               combo_fire;
    logic               combo_q;
    logic               combo_held;
    logic [NUM_BTN-1:0] freeze;

    assign o_Ms_Tick     = ms_tick_q;
    assign o_Combo_Reset = combo_q;
    assign combo_held    = o_Btn_Level[BTN_UP] & o_Btn_Level[BTN_DN];

    // Tick is registered from the next count so it is high exactly while the count sits at its last value.
    always_comb begin
        presc_nxt = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
    end

    // Combo counter saturates at full so a long hold fires only once.
    always_comb begin
        combo_cnt_nxt = combo_cnt_q;
        combo_fire    = 1'b0;
        if (!combo_held) begin
            combo_cnt_nxt = '0;
        end else if (ms_tick_q && (combo_cnt_q != CMB_FULL)) begin
            combo_cnt_nxt = combo_cnt_q + CMB_W'(1);
            combo_fire    = (combo_cnt_q == CMB_LAST);
        end
    end

    always_comb begin
        freeze         = '0;
        freeze[BTN_UP] = combo_held;
        freeze[BTN_DN] = combo_held;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            presc_q     <= '0;
            ms_tick_q   <= 1'b0;
            combo_cnt_q <= '0;
            combo_q     <= 1'b0;
        end else begin
            presc_q     <= presc_nxt;
            ms_tick_q   <= (presc_nxt == PS_LAST);
            combo_cnt_q <= combo_cnt_nxt;
            combo_q     <= combo_fire;
        end
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_btn (
            .i_Clk    (i_Clk),
            .i_Rst_n  (i_Rst_n),
            .i_Raw    (i_Btn_Raw[b]),
            .i_Tick   (ms_tick_q),
            .i_Freeze (freeze[b]),
            .o_Level  (o_Btn_Level[b]),
            .o_Pulse  (o_Move_Pulse[b])
        );
    end

endmodule
